ram_arbiter: RTL
================

# ram_arbiter

Two-requester arbiter that shares the single-port block RAM between the CPU data path (port A) and the program loader/debug path (port B). Each cycle it grants at most one access, using round-robin with bounded burst locking. It drives the RAM address, write-enable and write-data pins, and routes the one-cycle-latency read data back to the requester that issued the read. It sits between the requesters and the RAM instance and owns all RAM port muxing.

## Interface
- `addr_width`, default 8: RAM address width.
- `data_width`, default 8: RAM data width.
- `MAX_BURST`, default 16: maximum number of consecutive grants to one requester while the other is waiting. Must be ≥ 1.
- `clk` in 1: the single clock. All state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `a_req`, `b_req` in 1: access request. `req`, `we`, `addr`, `wdata` and `lock` stay stable until `gnt`.
- `a_we`, `b_we` in 1: 1 = write, 0 = read.
- `a_lock`, `b_lock` in 1: request to keep ownership for back-to-back accesses.
- `a_addr`, `b_addr` in `addr_width`: access address.
- `a_wdata`, `b_wdata` in `data_width`: write data.
- `a_gnt`, `b_gnt` out 1: combinational accept. A transfer occurs when `req & gnt` is true at the clock edge.
- `a_rvalid`, `b_rvalid` out 1: registered. Read data valid this cycle.
- `a_rdata`, `b_rdata` out `data_width`: read data. Meaningful only while the matching `rvalid` is high.
- `ram_addr` out `addr_width`: to the RAM address pin.
- `ram_we` out 1: to the RAM write-enable pin.
- `ram_din` out `data_width`: to the RAM data-in pin.
- `ram_dout` in `data_width`: from the RAM registered output.

## Operation
- **State.** `owner` (last-granted requester, A/B), `burst` counter (width `$clog2(MAX_BURST+1)`) and `rd_pend[1:0]` (one-hot owner of the outstanding read).
- **Grant, single request.** If only one requester asserts `req`, it is granted.
- **Grant, both requesting.** Default is to grant the requester that is not `owner`. Exception: if `owner` asserts `lock` and `burst < MAX_BURST`, `owner` is granted again.
- **Grant, no request.** No grant; `ram_we` = 0.
- **Counters on a grant.**
  - Same requester as `owner`: `burst` ← `burst` + 1, saturating at `MAX_BURST`.
  - Other requester: `owner` flips and `burst` ← 1.
  - Idle cycle (no grant): `burst` ← 0; `owner` unchanged.
- **MAX_BURST = 1.** Forces strict alternation whenever both requesters are requesting.
- **RAM muxing.** `ram_addr`, `ram_we` and `ram_din` come combinationally from the granted port. When there is no grant, `ram_addr` = `a_addr` (don't-care), `ram_din` = `a_wdata` and `ram_we` = 0.
- **Reads.** A granted read sets `rd_pend` for that requester for exactly the next cycle. In that cycle the requester's `rvalid` = 1 and its `rdata` = `ram_dout`.
- **Writes.** Writes produce no response.
- **Ordering.** Accesses execute in grant order.
  - A write granted in cycle N followed by a read of the same address granted in N+1 returns the new data.
  - Only one access is issued per cycle, so no same-cycle read/write collision exists.
- **`rdata` when idle.** `a_rdata` and `b_rdata` are both wired to `ram_dout`. Requesters must qualify them with `rvalid`.
- **Lock without request.** `lock` with `req` low is ignored.

## Timing
- **Reset values.** `owner` = B, so A wins the first contention. `burst` = 0. `rd_pend` = 0, so `a_rvalid` = `b_rvalid` = 0. `gnt` and `ram_*` are combinational from inputs and state.
- **Grant latency.** 0 cycles from request to `gnt` when uncontested.
- **Read latency.** 1 cycle from the grant edge to `rvalid`.
- **Throughput.** One access per cycle. Back-to-back reads give `rvalid` on consecutive cycles, possibly alternating between ports.
- **Worst-case wait.** A non-owner waits at most `MAX_BURST` cycles while the other requester holds `lock`.
- **Reset mid-read.** Asserting `rst_n` low with a read outstanding drops `rvalid` immediately, and the response is lost. The requester must reissue the read after reset.
- **Reset release.** First grant possible in the first cycle after `rst_n` deasserts.

## Structure
- **Shared package/header** (`mem_arb_defs`): requester ID constants `REQ_A` = 0, `REQ_B` = 1, and the default `addr_width`/`data_width`.
- **Sub-module** `arb2_pick`: purely combinational. Inputs are both `req`, both `lock`, `owner` and a `burst_full` flag. Outputs are the one-hot grant.
- **Top level:** `ram_arbiter` holds all registers and the RAM muxing.
- **RAM instance:** the RAM is instantiated by the parent, not inside `ram_arbiter`.

## Test plan
- **Reset, both request.** After reset, `a_req` = `b_req` = 1, both reads, no lock → grants A, B, A, B on cycles 0–3, each `rvalid` one cycle after the matching grant.
- **Write then read.** A writes 0x5A to address 0x10 in cycle N; B reads address 0x10 in N+1 → `b_rvalid` = 1 and `b_rdata` = 0x5A in N+2.
- **Lock, MAX_BURST = 4.** A holds `lock` with continuous reads while B requests → A granted 4 cycles, B on the 5th, then A again.
- **Idle resets burst.** A locked for 3 grants, one idle cycle, then A locked again with B waiting → A gets 4 more grants, because `burst` restarted at 0.
- **Reset mid-read.** A read of address 0x20 is granted; `rst_n` goes low before the next edge → `a_rvalid` stays 0, and after release `owner` = B, so A wins the next contention.
- **Single requester stream.** Only B requests: 8 writes, then 8 reads of addresses 0–7 → `b_gnt` every cycle, and the read data matches the written data with 1-cycle latency.

Source files
------------

// File: rtl/mem_arb_defs.sv
// Shared definitions for the two-port RAM arbiter: requester IDs, default widths
// and the owner encoding used by the arbiter and its pick logic.
package mem_arb_defs;

    localparam int REQ_A = 0;
    localparam int REQ_B = 1;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    // Width of a counter that must hold 0..max_burst inclusive.
    function automatic int burst_bits(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/arb2_pick.sv
// Combinational two-way pick: round-robin against the last owner, with the owner
// allowed to keep the grant while it holds lock and its burst budget is not spent.
module arb2_pick
    import mem_arb_defs::*;
(
    input  logic       a_req,
    input  logic       b_req,
    input  logic       a_lock,
    input  logic       b_lock,
    input  owner_e     owner,
    input  logic       burst_full,
    output logic [1:0] gnt
);

    logic owner_lock;
    logic pick_b;

    assign owner_lock = (owner == OWN_A) ? a_lock : b_lock;

    always_comb begin
        gnt    = 2'b00;
        pick_b = 1'b0;
        if (a_req && b_req) begin
            // Under contention the owner keeps the bus only while locked and under budget.
            if (owner_lock && !burst_full) begin
                pick_b = (owner == OWN_B);
            end else begin
                pick_b = (owner == OWN_A);
            end
            gnt[REQ_A] = !pick_b;
            gnt[REQ_B] = pick_b;
        end else begin
            gnt[REQ_A] = a_req;
            gnt[REQ_B] = b_req;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between requesters A and B: one access per cycle,
// round-robin with bounded lock bursts, and one-cycle read data routed back by owner.
module ram_arbiter
    import mem_arb_defs::*;
#(
    parameter int addr_width = DEF_ADDR_WIDTH,
    parameter int data_width = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic                  a_lock,
    input  logic [addr_width-1:0] a_addr,
    input  logic [data_width-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [data_width-1:0] a_rdata,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic                  b_lock,
    input  logic [addr_width-1:0] b_addr,
    input  logic [data_width-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [data_width-1:0] b_rdata,

    output logic [addr_width-1:0] ram_addr,
    output logic                  ram_we,
    output logic [data_width-1:0] ram_din,
    input  logic [data_width-1:0] ram_dout
);

    // Handshake: a requester holds req/we/lock/addr/wdata stable until gnt; an access
    // happens on the rising edge where req & gnt; a read answers with rvalid one cycle later.

    localparam int               BW        = burst_bits(MAX_BURST);
    localparam logic [BW-1:0]    BURST_MAX = BW'(MAX_BURST);

    owner_e        owner_q, owner_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [1:0]    rd_pend_q, rd_pend_d;

    logic [1:0]    gnt;
    logic          any_gnt;
    owner_e        gnt_id;
    logic          burst_full;

    assign burst_full = (burst_q >= BURST_MAX);
    assign any_gnt    = gnt[REQ_A] | gnt[REQ_B];
    assign gnt_id     = gnt[REQ_B] ? OWN_B : OWN_A;

    arb2_pick u_pick (
        .a_req      (a_req),
        .b_req      (b_req),
        .a_lock     (a_lock),
        .b_lock     (b_lock),
        .owner      (owner_q),
        .burst_full (burst_full),
        .gnt        (gnt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q   <= OWN_B;
            burst_q   <= '0;
            rd_pend_q <= 2'b00;
        end else begin
            owner_q   <= owner_d;
            burst_q   <= burst_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // Next-state: burst counts consecutive grants to the owner and restarts on idle.
    always_comb begin
        owner_d   = owner_q;
        burst_d   = burst_q;
        rd_pend_d = 2'b00;
        if (any_gnt) begin
            if (gnt_id == owner_q) begin
                if (burst_q != BURST_MAX) begin
                    burst_d = burst_q + BW'(1);
                end
            end else begin
                owner_d = gnt_id;
                burst_d = BW'(1);
            end
        end else begin
            burst_d = '0;
        end
        rd_pend_d[REQ_A] = gnt[REQ_A] & ~a_we;
        rd_pend_d[REQ_B] = gnt[REQ_B] & ~b_we;
    end

    // Outputs: RAM pins follow the granted port, defaulting to port A with writes off.
    always_comb begin
        a_gnt    = gnt[REQ_A];
        b_gnt    = gnt[REQ_B];
        a_rvalid = rd_pend_q[REQ_A];
        b_rvalid = rd_pend_q[REQ_B];
        a_rdata  = ram_dout;
        b_rdata  = ram_dout;
        ram_addr = a_addr;
        ram_din  = a_wdata;
        ram_we   = 1'b0;
        if (gnt[REQ_B]) begin
            ram_addr = b_addr;
            ram_din  = b_wdata;
            ram_we   = b_we;
        end else if (gnt[REQ_A]) begin
            ram_we   = a_we;
        end
    end

endmodule
